// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target and an iterative shift-add multiplier feeding EX/MEM.
// Latency 1 cycle (mul: WIDTH+1 cycles); stall holds IF/ID and ID/EX while a multiply runs.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inR1,
  input  logic [WIDTH-1:0] inR2,
  input  logic [WIDTH-1:0] inAddress,
  input  logic [WIDTH-1:0] inPc,
  input  logic [1:0]       inAluCtrl,
  input  logic [0:8]       inControlBits,
  input  logic [4:0]       inWriteRegister,
  input  logic             inValid,
  input  logic             inFlush,
  output logic             stall,
  output logic [WIDTH-1:0] outAluResult,
  output logic [WIDTH-1:0] outR2,
  output logic [WIDTH-1:0] outBranchTarget,
  output logic             outZero,
  output logic [0:8]       outControlBits,
  output logic [4:0]       outWriteRegister,
  output logic             outValid
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0] acc_next, alu_res, res_d;
  logic [5:0]       funct;
  logic             is_mul, mul_start, mul_last, valid_d;

  assign funct     = inAddress[5:0];
  assign is_mul    = (inAluCtrl == 2'b10) && (funct == 6'h18);
  assign mul_start = (state_q == IDLE) && inValid && is_mul && !inFlush;
  assign mul_last  = (state_q == MUL) && (count_q == CW'(WIDTH-1));
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = inR1 + inR2;
    case (inAluCtrl)
      2'b01: alu_res = inR1 - inR2;
      2'b10: begin
        case (funct)
          6'h22:   alu_res = inR1 - inR2;
          6'h24:   alu_res = inR1 & inR2;
          6'h25:   alu_res = inR1 | inR2;
          6'h2A:   alu_res = ($signed(inR1) < $signed(inR2)) ? WIDTH'(1) : '0;
          default: alu_res = inR1 + inR2;
        endcase
      end
      default: alu_res = inR1 + inR2;
    endcase
  end

  // stall is a pure function of FSM state and the presented instruction.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    valid_d = 1'b0;
    if (inFlush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (mul_start) begin
        state_d = MUL;
        stall   = 1'b1;
      end else begin
        valid_d = inValid;
      end
    end else if (mul_last) begin
      state_d = IDLE;
      valid_d = 1'b1;
    end else begin
      stall = 1'b1;
    end
    if (!reset) stall = 1'b0;
  end

  assign res_d = (state_q == MUL) ? acc_next : alu_res;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mcand_q  <= inR1;
        mplier_q <= inR2;
        acc_q    <= '0;
        count_q  <= '0;
      end else if (state_q == MUL) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_next;
        count_q  <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outAluResult     <= '0;
      outR2            <= '0;
      outBranchTarget  <= '0;
      outZero          <= 1'b0;
      outControlBits   <= '0;
      outWriteRegister <= '0;
      outValid         <= 1'b0;
    end else begin
      outAluResult     <= res_d;
      outR2            <= inR2;
      outBranchTarget  <= inPc + (inAddress << 2);
      outZero          <= (res_d == '0);
      outControlBits   <= inControlBits;
      outWriteRegister <= inWriteRegister;
      outValid         <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, randomized ops against a reference model, multiply/flush/reset sequences.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inR1, inR2, inAddress, inPc;
  logic [1:0]  inAluCtrl;
  logic [0:8]  inControlBits;
  logic [4:0]  inWriteRegister;
  logic        inValid, inFlush;
  logic        stall;
  logic [31:0] outAluResult, outR2, outBranchTarget;
  logic        outZero;
  logic [0:8]  outControlBits;
  logic [4:0]  outWriteRegister;
  logic        outValid;

  int tests = 0;
  int fails = 0;

  ex_stage #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .inR1(inR1), .inR2(inR2), .inAddress(inAddress),
    .inPc(inPc), .inAluCtrl(inAluCtrl), .inControlBits(inControlBits),
    .inWriteRegister(inWriteRegister), .inValid(inValid), .inFlush(inFlush),
    .stall(stall), .outAluResult(outAluResult), .outR2(outR2),
    .outBranchTarget(outBranchTarget), .outZero(outZero),
    .outControlBits(outControlBits), .outWriteRegister(outWriteRegister),
    .outValid(outValid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] r1, r2, addr, pc;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference ALU, written directly from the opcode rules.
  function automatic logic [31:0] ref_alu(input logic [1:0] ctrl, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    if (ctrl == 2'b01) return a - b;
    if (ctrl == 2'b10) begin
      if (f == 6'h22) return a - b;
      if (f == 6'h24) return a & b;
      if (f == 6'h25) return a | b;
      if (f == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
    end
    return a + b;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] addr, input logic [31:0] pc, input logic v);
    inAluCtrl = ctrl; inR1 = a; inR2 = b; inAddress = addr; inPc = pc; inValid = v;
    inControlBits = 9'($urandom); inWriteRegister = 5'($urandom);
  endtask

  // Present one single-cycle op and check everything one edge later.
  task automatic single(input string name, input logic [31:0] exp_res);
    logic [0:8]  cb;
    logic [4:0]  wr;
    logic [31:0] bt, r2;
    cb = inControlBits; wr = inWriteRegister; r2 = inR2;
    bt = inPc + inAddress * 4;
    #1;
    chk({name, ".stall"}, 32'(stall), 32'd0);
    next_cycle();
    chk({name, ".valid"}, 32'(outValid), 32'd1);
    chk({name, ".res"}, outAluResult, exp_res);
    chk({name, ".zero"}, 32'(outZero), 32'(exp_res == 0));
    chk({name, ".bt"}, outBranchTarget, bt);
    chk({name, ".r2"}, outR2, r2);
    chk({name, ".cb_wr"}, {18'd0, 5'(outWriteRegister), outControlBits}, {18'd0, wr, cb});
  endtask

  // Multiply: count stall cycles and edges until outValid, bounded.
  task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b);
    int stalls, edges;
    logic [31:0] prod;
    prod = a * b;
    drive(2'b10, a, b, 32'h18, 32'h40, 1'b1);
    stalls = 0; edges = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall) stalls++;
      next_cycle();
      edges++;
      if (outValid) break;
    end
    chk({name, ".stalls"}, 32'(stalls), 32'd32);
    chk({name, ".edges"}, 32'(edges), 32'd33);
    chk({name, ".res"}, outAluResult, prod);
    inValid = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 32'd5, 32'd7, 32'd0, 32'h0, 32'd12, 1'b0};
    vecs[1] = '{2'b01, 32'd9, 32'd9, 32'd0, 32'h0, 32'd0, 1'b1};
    vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'h0, 32'd1, 1'b0};
    vecs[3] = '{2'b10, 32'd1, 32'hFFFFFFFF, 32'h2A, 32'h0, 32'd0, 1'b1};
    vecs[4] = '{2'b10, 32'hF0F0, 32'hFF00, 32'h24, 32'h0, 32'hF000, 1'b0};
    vecs[5] = '{2'b10, 32'hF0F0, 32'h0F00, 32'h25, 32'h0, 32'hFFF0, 1'b0};
    vecs[6] = '{2'b10, 32'd3, 32'd10, 32'h22, 32'h0, 32'hFFFFFFF9, 1'b0};
    vecs[7] = '{2'b10, 32'd3, 32'd10, 32'h3F, 32'h0, 32'd13, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'd0, 1'b1};
    vecs[9] = '{2'b00, 32'd0, 32'd0, 32'd3, 32'h100, 32'd0, 1'b1};

    reset = 1'b0; inFlush = 1'b0;
    drive(2'b00, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1);
    next_cycle(); next_cycle();
    chk("rst.valid", 32'(outValid), 32'd0);
    chk("rst.res", outAluResult, 32'd0);
    chk("rst.bt_r2", outBranchTarget | outR2, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
    chk("rst_rel.valid", 32'(outValid), 32'd1);
    chk("rst_rel.res", outAluResult, 32'd12);

    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].r1, vecs[i].r2, vecs[i].addr, vecs[i].pc, 1'b1);
      single($sformatf("vec%0d", i), vecs[i].exp_res);
      chk($sformatf("vec%0d.tblzero", i), 32'(outZero), 32'(vecs[i].exp_zero));
    end
    chk("branch_0x10C", outBranchTarget, 32'h10C);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  c;
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [5:0]  fl[6];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
      c = 2'($urandom);
      f = fl[$urandom_range(0, 5)];
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(c, a, b, {$urandom} & 32'hFFFF_FFC0 | 32'(f), $urandom, 1'b1);
      single($sformatf("rnd%0d", i), ref_alu(c, f, a, b));
    end

    inValid = 1'b0;
    next_cycle();
    chk("idle.valid", 32'(outValid), 32'd0);

    mul_op("mul_ffff", 32'hFFFF, 32'h10001);
    mul_op("mul_msb", 32'h80000000, 32'd2);
    drive(2'b00, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1);
    single("after_mul", 32'd3);
    for (int i = 0; i < 3; i++) mul_op($sformatf("mulrnd%0d", i), $urandom, $urandom);
    mul_op("mul_b2b", 32'd6, 32'd7);

    // Flush during MUL at count 10.
    drive(2'b10, 32'd5, 32'd5, 32'h18, 32'h0, 1'b1);
    for (int i = 0; i < 11; i++) next_cycle();
    inFlush = 1'b1;
    #1;
    chk("flush10.stall_now", 32'(stall), 32'd0);
    next_cycle();
    inFlush = 1'b0; inValid = 1'b0;
    #1;
    chk("flush10.valid", 32'(outValid), 32'd0);
    chk("flush10.idle_stall", 32'(stall), 32'd0);
    next_cycle();
    chk("flush10.no_result", 32'(outValid), 32'd0);
    drive(2'b00, 32'd20, 32'd22, 32'd0, 32'h0, 1'b1);
    single("flush10.add", 32'd42);

    // Flush coinciding with the final multiply cycle.
    drive(2'b10, 32'd9, 32'd9, 32'h18, 32'h0, 1'b1);
    for (int i = 0; i < 32; i++) next_cycle();
    inFlush = 1'b1;
    next_cycle();
    inFlush = 1'b0; inValid = 1'b0;
    chk("flush31.valid", 32'(outValid), 32'd0);
    next_cycle();
    chk("flush31.valid2", 32'(outValid), 32'd0);

    // Flush wins over a new mul in IDLE.
    drive(2'b10, 32'd2, 32'd2, 32'h18, 32'h0, 1'b1);
    inFlush = 1'b1;
    #1;
    chk("flush_idle.stall", 32'(stall), 32'd0);
    next_cycle();
    inFlush = 1'b0; inValid = 1'b0;
    #1;
    chk("flush_idle.not_mul", 32'(stall), 32'd0);

    // Reset mid-multiply.
    drive(2'b10, 32'd7, 32'd7, 32'h18, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) next_cycle();
    reset = 1'b0;
    #1;
    chk("rstmul.res", outAluResult | outR2 | outBranchTarget, 32'd0);
    chk("rstmul.valid", 32'(outValid), 32'd0);
    inValid = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    chk("rstmul.idle", 32'(stall) | 32'(outValid), 32'd0);
    mul_op("rstmul.3x4", 32'd3, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
